// File: rtl/hsbus_mem_responder_pkg.sv
// Shared types for the high-speed bus memory responder: store width encoding,
// responder FSM states and the byte-enable helper used by the lane aligner.
package hsbus_mem_responder_pkg;

    typedef enum logic [1:0] {
        WidthByte = 2'b00,
        WidthHalf = 2'b01,
        WidthWord = 2'b10
    } width_e;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } state_e;

    // Byte-enable mask for a store; all-zero means misaligned or illegal width.
    function automatic logic [3:0] byte_enables(input logic [1:0] width,
                                                input logic [1:0] offset);
        logic [3:0] be;
        be = 4'b0000;
        case (width)
            WidthByte: be = 4'b0001 << offset;
            WidthHalf: be = offset[0] ? 4'b0000 : (offset[1] ? 4'b1100 : 4'b0011);
            WidthWord: be = (offset == 2'b00) ? 4'b1111 : 4'b0000;
            default:   be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/hsbus_byte_lane_align.sv
// Store lane aligner: turns a right-justified store into byte enables and
// lane-positioned data, and flags misaligned or illegal-width stores.
module hsbus_byte_lane_align
    import hsbus_mem_responder_pkg::*;
(
    input  logic [1:0]  width,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    output logic [3:0]  byte_en,
    output logic [31:0] lane_data,
    output logic        misalign
);

    // Replicating the data across lanes puts it in every possible lane; the
    // byte enables pick the one that is actually written.
    always_comb begin
        byte_en   = byte_enables(width, offset);
        misalign  = (byte_en == 4'b0000);
        lane_data = wdata;
        case (width)
            WidthByte: lane_data = {4{wdata[7:0]}};
            WidthHalf: lane_data = {2{wdata[15:0]}};
            default:   lane_data = wdata;
        endcase
    end

endmodule

// File: rtl/hsbus_mem_responder.sv
// High-speed bus memory responder: decodes its address window, stalls the core
// for WAIT_STATES+2 cycles per access and presents read data in DONE only, so
// several responders can be OR-combined.
// Optional: define HSBUS_RESP_ACCESS_CNT_EN to add rd_count/wr_count outputs.
module hsbus_mem_responder
    import hsbus_mem_responder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst_sync,
    input  logic        bus_read,
    input  logic        bus_write,
    input  logic [1:0]  bus_write_width,
    input  logic [31:0] bus_raddr,
    input  logic [31:0] bus_waddr,
    input  logic [31:0] bus_wdata,
    input  logic        core_stall_n,
    output logic [31:0] bus_rdata,
    output logic        stall_req,
    output logic        access_err
`ifdef HSBUS_RESP_ACCESS_CNT_EN
    ,
    output logic [31:0] rd_count,
    output logic [31:0] wr_count
`endif
);

    localparam int unsigned AW = $clog2(DEPTH * 4);
    localparam int unsigned IW = AW - 2;

    logic [31:0]   sel_addr;
    logic          hit;
    logic          idle_req;
    logic          start;
    logic          commit;
    logic [3:0]    be;
    logic [31:0]   lane_data;
    logic          misalign;

    state_e        state_q;
    logic [3:0]    cnt_q;
    logic          wr_q;
    logic [IW-1:0] idx_q;
    logic [3:0]    be_q;
    logic [31:0]   wdata_q;
    logic [31:0]   rdata_q;

    logic [31:0]   mem [DEPTH];

    hsbus_byte_lane_align u_align (
        .width     (bus_write_width),
        .offset    (sel_addr[1:0]),
        .wdata     (bus_wdata),
        .byte_en   (be),
        .lane_data (lane_data),
        .misalign  (misalign)
    );

    // Address decode and same-cycle handshake outputs.
    always_comb begin
        sel_addr   = bus_write ? bus_waddr : bus_raddr;
        hit        = (sel_addr[31:AW] == BASE_ADDR[31:AW]);
        idle_req   = (state_q == StIdle) && !rst_sync && hit && (bus_read || bus_write);
        start      = idle_req && !(bus_write && misalign);
        // A simultaneous read+write still services the write but is flagged.
        access_err = idle_req && ((bus_read && bus_write) || (bus_write && misalign));
        stall_req  = start || (state_q == StBusy);
        commit     = (state_q == StBusy) && (cnt_q == 4'd0);
        bus_rdata  = (state_q == StDone) ? rdata_q : 32'h0;
    end

    // Responder FSM: latch request, count wait states, access, hold in DONE.
    always_ff @(posedge clk) begin
        if (rst_sync) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            wr_q    <= 1'b0;
            idx_q   <= '0;
            be_q    <= 4'b0000;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
`ifdef HSBUS_RESP_ACCESS_CNT_EN
            rd_count <= 32'h0;
            wr_count <= 32'h0;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        wr_q    <= bus_write;
                        idx_q   <= sel_addr[AW-1:2];
                        be_q    <= be;
                        wdata_q <= lane_data;
                        cnt_q   <= 4'(WAIT_STATES);
                        state_q <= StBusy;
                    end
                end
                StBusy: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        rdata_q <= wr_q ? 32'h0 : mem[idx_q];
                        state_q <= StDone;
`ifdef HSBUS_RESP_ACCESS_CNT_EN
                        if (wr_q) wr_count <= wr_count + 32'd1;
                        else      rd_count <= rd_count + 32'd1;
`endif
                    end
                end
                StDone: begin
                    if (core_stall_n) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Memory array write port; contents survive reset, pending writes do not.
    always_ff @(posedge clk) begin
        if (!rst_sync && commit && wr_q) begin
            for (int b = 0; b < 4; b++) begin
                if (be_q[b]) mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
            end
        end
    end

endmodule

// File: doc/hsbus_mem_responder.md
Name: hsbus_mem_responder

Overview:
Responder end of the core's high-speed data bus: services the load/store requests (read/write, width, raddr/waddr, wdata) that the RISC-V core issues from its EX stage.
- Fronts an on-chip synchronous word memory with a configurable number of wait states.
- Holds the core through its stall_req input until the access completes.
- One instance per memory region; decodes its own address window and stays silent outside it, so several responders can be OR-combined.

Parameters:
BASE_ADDR, 32'h0001_0000, byte address of window start; must be aligned to DEPTH*4.
DEPTH, 1024, number of 32-bit words; power of two.
WAIT_STATES, 1, extra busy cycles before the memory access cycle; range 0..15.

Ports:
clk  input  1  system clock; all logic is on its rising edge.
rst_sync  input  1  synchronous reset, active high.
bus_read  input  1  core load request (access_ram_read).
bus_write  input  1  core store request (access_ram_write).
bus_write_width  input  2  2'b00 byte, 2'b01 halfword, 2'b10 word; 2'b11 is illegal.
bus_raddr  input  32  load byte address.
bus_waddr  input  32  store byte address.
bus_wdata  input  32  store data, right-justified (byte in [7:0], halfword in [15:0]).
core_stall_n  input  1  core advancing; low means the pipeline is frozen by any source.
bus_rdata  output  32  aligned word containing the load target; core performs lane select/extension.
stall_req  output  1  to one bit of the core's stall_req vector.
access_err  output  1  one-cycle pulse: misaligned access or illegal width inside window.

Behaviour:
- Reset (rst_sync=1 at a clock edge):
  - FSM goes to IDLE; stall_req=0, bus_rdata=0, access_err=0.
  - Latched request is discarded; a write not yet committed is never performed. Memory contents are not cleared.
- Hit: selected address (waddr if bus_write, else raddr) has addr[31:log2(DEPTH*4)] equal to BASE_ADDR's upper bits. Word index = addr[log2(DEPTH*4)-1:2].
- Both bus_read and bus_write high: the write is serviced, the read is ignored and access_err pulses.
- Alignment:
  - Halfword needs addr[0]=0; word needs addr[1:0]=0; width 2'b11 is illegal.
  - Misaligned or illegal hit: no memory access, no stall, access_err=1 for that one cycle.
- FSM states IDLE, BUSY, DONE:
  - IDLE, valid aligned hit: stall_req=1 combinationally in the same cycle. Latch op, index, byte enables and shifted wdata. Load cnt=WAIT_STATES. Go to BUSY.
  - BUSY: stall_req=1; bus inputs ignored.
    - cnt!=0: decrement.
    - cnt==0: perform the memory access, go to DONE.
    - Write: byte enables apply (byte lanes set by addr[1:0], halfword by addr[1]) and wdata is shifted into the lane.
    - Read: word registered into rdata_q.
  - DONE: stall_req=0; bus_rdata=rdata_q (0 for writes).
    - Stay in DONE while core_stall_n=0, holding bus_rdata stable and not re-decoding the still-present request.
    - Return to IDLE on core_stall_n=1.
- Latency: stall_req high for WAIT_STATES+2 cycles (request cycle + WAIT_STATES + access cycle); data valid in the first DONE cycle.
- Back-to-back: the request in the cycle after DONE is treated as new; minimum throughput is one access per WAIT_STATES+3 cycles.
- Miss, or IDLE with no request: stall_req=0, bus_rdata=0, access_err=0.
- Outside DONE, bus_rdata is always 0, so it is OR-safe.

Optional Feature:
HSBUS_RESP_ACCESS_CNT_EN:
- Defined: adds outputs rd_count[31:0] and wr_count[31:0].
- Each counter increments by 1 on the BUSY->DONE transition of a committed read or write.
- Counters wrap at 2^32 and reset to 0 on rst_sync. Errored accesses are not counted.
- Undefined: ports and counters are absent; all other behaviour is unchanged.

Decomposition:
- Package HSBus_Typedefs:
  - Width encoding enum (WIDTH_BYTE, WIDTH_HALF, WIDTH_WORD).
  - Responder FSM state enum (IDLE, BUSY, DONE).
  - Function returning the byte-enable mask for a width/offset.
- Sub-module hsbus_byte_lane_align (combinational): width + addr[1:0] + right-justified wdata -> 4-bit byte enables, lane-shifted data, misalign flag.

Test Plan:
1. WAIT_STATES=1: word write 32'hDEADBEEF to BASE+0x10, then word read of the same address -> stall_req high 3 cycles each; bus_rdata=32'hDEADBEEF in DONE; access_err never set.
2. Word 32'h11223344 at BASE+0x20; byte write 8'hAA to BASE+0x23; halfword write 16'h5566 to BASE+0x20; read -> 32'hAA22_5566.
3. Halfword write to BASE+0x21 -> access_err pulses 1 cycle; stall_req stays 0; a following read of BASE+0x20 returns the old value.
4. Read of BASE+DEPTH*4 (miss) -> stall_req=0, bus_rdata=0 throughout.
5. Read completes with core_stall_n=0 for 3 cycles after DONE -> FSM holds DONE with bus_rdata stable and no second access; returns to IDLE when core_stall_n rises.
6. Word write with rst_sync asserted in the BUSY cycle where cnt==0 -> outputs 0 next cycle; a subsequent read shows the old memory content. With HSBUS_RESP_ACCESS_CNT_EN, wr_count=0.
